// File: rtl/toggle_counter.sv
// Vector toggle register / counter: hold, count up, count down and masked toggle,
// with synchronous load, programmable terminal value and wrap-or-saturate policy.
module toggle_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Terminal detection is by compare against MAX_V, never by carry/borrow.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = (d > MAX_V) ? MAX_V : d;
        end else if (en) begin
            case (mode_s)
                MODE_UP: begin
                    if (q_q < MAX_V) begin
                        q_d = q_q + ONE_V;
                    end else begin
                        tc_d = 1'b1;
                        q_d  = SATURATE ? MAX_V : '0;
                    end
                end
                MODE_DOWN: begin
                    if (q_q == '0) begin
                        tc_d = 1'b1;
                        q_d  = SATURATE ? '0 : MAX_V;
                    end else if (q_q > MAX_V) begin
                        q_d = MAX_V;
                    end else begin
                        q_d = q_q - ONE_V;
                    end
                end
                MODE_TOGGLE: q_d = q_q ^ t;
                default:     q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_toggle_counter.sv
// Directed bench: two WIDTH=4/MAX=9 instances (wrap and saturate) share stimulus.
module tb_toggle_counter;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [1:0] mode;
    logic [3:0] t, d;
    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, zero_w, zero_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_counter #(.WIDTH(4), .MAX(64'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .q(q_w), .tc(tc_w), .zero(zero_w)
    );

    toggle_counter #(.WIDTH(4), .MAX(64'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .q(q_s), .tc(tc_s), .zero(zero_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic [1:0] m,
                         input logic [3:0] tv, input logic [3:0] dv);
        rst = r; load = l; en = e; mode = m; t = tv; d = dv;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        step();
        chk("rst_q_w", q_w, 0);
        chk("rst_tc_w", tc_w, 0);
        chk("rst_zero_w", zero_w, 1);
        chk("rst_q_s", q_s, 0);
        chk("rst_tc_s", tc_s, 0);

        drive(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("up_q_w", q_w, i % 10);
            chk("up_tc_w", tc_w, (i == 10) ? 1 : 0);
            chk("up_zero_w", zero_w, (i == 10) ? 1 : 0);
            chk("up_q_s", q_s, (i < 9) ? i : 9);
            chk("up_tc_s", tc_s, (i >= 10) ? 1 : 0);
        end

        drive(1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        step();
        chk("midrst_q_w", q_w, 0);
        chk("midrst_tc_w", tc_w, 0);
        chk("midrst_tc_s", tc_s, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dn_q_w", q_w, 9 - i);
            chk("dn_tc_w", tc_w, (i == 0) ? 1 : 0);
            chk("dn_q_s", q_s, 0);
            chk("dn_tc_s", tc_s, 1);
        end

        drive(1'b0, 1'b1, 1'b1, 2'b10, 4'h0, 4'hF);
        step();
        chk("ldclamp_q_w", q_w, 9);
        chk("ldclamp_q_s", q_s, 9);
        chk("ldclamp_tc_s", tc_s, 0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, 4'b0110, 4'h0);
        step();
        chk("tog_q_w", q_w, 4'hF);
        chk("tog_tc_w", tc_w, 0);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        step();
        chk("dnabove_q_w", q_w, 9);
        chk("dnabove_tc_w", tc_w, 0);
        chk("dnabove_q_s", q_s, 9);

        drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'h5);
        step();
        chk("ldwins_q_w", q_w, 5);
        chk("ldwins_tc_w", tc_w, 0);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 4'h0, 4'h3);
        step();
        chk("rstwins_q_w", q_w, 0);
        chk("rstwins_tc_w", tc_w, 0);

        drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h6);
        step();
        chk("ld6_q_w", q_w, 6);
        drive(1'b0, 1'b0, 1'b0, 2'b01, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en0_q_w", q_w, 6);
            chk("en0_tc_w", tc_w, 0);
        end
        drive(1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0);
        step();
        chk("hold_q_w", q_w, 6);
        drive(1'b0, 1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        step();
        chk("tog0_q_w", q_w, 6);
        drive(1'b0, 1'b0, 1'b1, 2'b11, 4'hF, 4'h0);
        step();
        chk("togF1_q_w", q_w, 9);
        chk("togF1_zero_w", zero_w, 0);
        step();
        chk("togF2_q_w", q_w, 6);
        chk("togF2_q_s", q_s, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Parametrised WIDTH-bit register bank with per-bit toggle control, generalising the single-bit toggle flip-flop to a vector. It supports four operating modes (hold, count up, count down, masked toggle), synchronous load, a programmable terminal value, and a wrap or saturate policy. It serves as the general-purpose counter / toggle register for the sequential-circuit library and replaces ad-hoc chains of single toggle stages.

## Interface
- WIDTH, 8, register width in bits (≥1)
- MAX, 2**WIDTH-1, terminal value for count modes (0 < MAX ≤ 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal

- clk  in  1  rising-edge clock; all state changes on posedge clk
- rst  in  1  reset; synchronous, active-high
- en  in  1  mode enable; when low, the mode field is ignored and q holds (load still acts)
- mode  in  2  00 hold, 01 count up, 10 count down, 11 masked toggle
- t  in  WIDTH  toggle mask, used only in mode 11
- load  in  1  synchronous load strobe
- d  in  WIDTH  load data
- q  out  WIDTH  register value (registered)
- tc  out  1  terminal-count pulse (registered)
- zero  out  1  combinational, high when q == 0

## Operation
- Priority per edge: rst > load > (en && mode) > hold.
- rst: q ← 0, tc ← 0. This is the only defined initial state. Before the first reset, q is X in simulation, and no X-masking logic is permitted.
- load: q ← min(d, MAX). tc ← 0. Both en and mode are ignored.
- Hold (mode 00, or en = 0 without load): q unchanged, tc ← 0.
- Count up (01):
  - if q < MAX: q ← q+1, tc ← 0.
  - if q ≥ MAX: tc ← 1, and q ← 0 (SATURATE=0) or q ← MAX (SATURATE=1).
- Count down (10):
  - if q == 0: tc ← 1, and q ← MAX (SATURATE=0) or q ← 0 (SATURATE=1).
  - if 0 < q ≤ MAX: q ← q−1, tc ← 0.
  - if q > MAX (possible only after mode 11): q ← MAX, tc ← 0.
- Masked toggle (11): q ← q ^ t, bitwise, so each bit behaves as an independent toggle flip-flop with T = t[i]. The result is not clamped to MAX. tc ← 0.
- Arithmetic is WIDTH-bit unsigned. No carry or borrow leaves the block; terminal detection uses the compares above, never the arithmetic overflow.
- zero decodes the current q and has no state.

## Timing
- Latency: one clock. Inputs sampled at edge n appear on q/tc after edge n.
- tc is high for exactly the one cycle in which q shows the wrapped or saturated value.
- With SATURATE=1 and sustained counting at the terminal, tc stays high every cycle (one pulse per attempted step).
- Simultaneous events:
  - rst with load: reset wins.
  - load with en/mode: load wins, and tc is 0 in the next cycle.
- Reset mid-count: the next cycle shows q = 0, tc = 0 regardless of mode. Counting resumes on the following edge if en = 1.
- Mode changes take effect on the edge where they are sampled. There is no pipeline and no history dependence except q itself.

## Test plan
- Reset, then mode 01 with en=1 (WIDTH=4, MAX=9, SATURATE=0) for 12 cycles → q = 1..9, 0, 1, 2; tc=1 only in the cycle q returns to 0; zero=1 in that same cycle.
- Same configuration with SATURATE=1, up for 12 cycles → q climbs to 9 and stays at 9; tc=1 on every cycle after q first reaches 9.
- Down from reset (SATURATE=0) → first cycle q=9 with tc=1, then 8, 7, …
- Load d=4'hF with MAX=9 → q=9. Then mode 11 with t=4'b0110 → q=4'hF (0b1001 ^ 0b0110). Then mode 10 → q=9 with tc=0.
- Assert load d=5 together with mode 01/en=1 → q=5, not 6. Then assert rst together with load d=3 → q=0, tc=0.
- Hold checks: en=0 with mode 01 for 5 cycles leaves q unchanged and tc=0. Mode 11 with t=0 leaves q unchanged. Mode 11 with t=all-ones twice returns q to its original value.
